// File: rtl/lives_display_ctrl.sv
// Player life counter with invulnerability/blink handling and
// per-pixel heart slot hit test feeding the heart bitmap stage.
module lives_display_ctrl #(
   parameter int MAX_LIVES     = 5,
   parameter int INIT_LIVES    = 3,
   parameter int TOPLEFT_X     = 16,
   parameter int TOPLEFT_Y     = 8,
   parameter int HEART_SIZE    = 32,
   parameter int SPACING       = 36,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        playerHit,
   input  logic        lifePickup,
   input  logic        gameRestart,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic [2:0]  livesCount,
   output logic        invulnerable,
   output logic        gameOver
);

   typedef enum logic [1:0] {ALIVE, INVULN, GAME_OVER} state_t;

   localparam int CW = $clog2(INVULN_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [2:0]  MAXL = 3'(MAX_LIVES);
   localparam logic [2:0]  INIT = 3'(INIT_LIVES);
   localparam logic [10:0] TOP  = 11'(TOPLEFT_Y);
   localparam logic [10:0] HS   = 11'(HEART_SIZE);

   state_t         state, state_nx;
   logic [2:0]     lives, lives_nx, lives_inc;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [BW-1:0]  blink_cnt, blink_cnt_nx;
   logic           blink, blink_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ALIVE;
         lives     <= INIT;
         cnt       <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else begin
         state     <= state_nx;
         lives     <= lives_nx;
         cnt       <= cnt_nx;
         blink_cnt <= blink_cnt_nx;
         blink     <= blink_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      lives_nx     = lives;
      cnt_nx       = cnt;
      blink_cnt_nx = blink_cnt;
      blink_nx     = blink;
      lives_inc    = (lives == MAXL) ? lives : lives + 3'd1;
      if (gameRestart) begin
         state_nx     = ALIVE;
         lives_nx     = INIT;
         cnt_nx       = '0;
         blink_cnt_nx = '0;
         blink_nx     = 1'b0;
      end else begin
         unique case (state)
            ALIVE: begin
               if (playerHit && lifePickup) begin
                  // a pickup on the last life cancels the hit entirely
                  if (lives != 3'd1) begin
                     state_nx     = INVULN;
                     cnt_nx       = CW'(INVULN_FRAMES);
                     blink_cnt_nx = '0;
                     blink_nx     = 1'b0;
                  end
               end else if (playerHit) begin
                  lives_nx = lives - 3'd1;
                  if (lives == 3'd1) begin
                     state_nx = GAME_OVER;
                  end else begin
                     state_nx     = INVULN;
                     cnt_nx       = CW'(INVULN_FRAMES);
                     blink_cnt_nx = '0;
                     blink_nx     = 1'b0;
                  end
               end else if (lifePickup) begin
                  lives_nx = lives_inc;
               end
            end
            INVULN: begin
               if (lifePickup) lives_nx = lives_inc;
               if (startOfFrame) begin
                  if (cnt == CW'(1)) begin
                     state_nx     = ALIVE;
                     cnt_nx       = '0;
                     blink_cnt_nx = '0;
                     blink_nx     = 1'b0;
                  end else begin
                     cnt_nx = cnt - CW'(1);
                     if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                        blink_cnt_nx = '0;
                        blink_nx     = ~blink;
                     end else begin
                        blink_cnt_nx = blink_cnt + BW'(1);
                     end
                  end
               end
            end
            GAME_OVER: ;
            default: state_nx = ALIVE;
         endcase
      end
   end

   logic                 in_y;
   logic [MAX_LIVES-1:0] slot_hit;
   logic [10:0]          slot_x [MAX_LIVES];

   assign in_y = (pixelY >= TOP) && (pixelY < TOP + HS);

   for (genvar i = 0; i < MAX_LIVES; i++) begin : g_slot
      localparam logic [10:0] LEFT = 11'(TOPLEFT_X + i * SPACING);
      logic vis;
      assign vis = (3'(i) < lives) ||
                   ((state == INVULN) && (3'(i) == lives) && blink);
      assign slot_hit[i] = vis && in_y &&
                           (pixelX >= LEFT) && (pixelX < LEFT + HS);
      assign slot_x[i] = pixelX - LEFT;
   end

   logic        inside_c;
   logic [10:0] ox_c, oy_c;

   // slots never overlap, so OR-ing the gated offsets is a clean mux
   always_comb begin
      inside_c = |slot_hit;
      ox_c     = '0;
      for (int i = 0; i < MAX_LIVES; i++) begin
         if (slot_hit[i]) ox_c = ox_c | slot_x[i];
      end
      oy_c = inside_c ? pixelY - TOP : 11'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         InsideRectangle <= 1'b0;
         offsetX         <= '0;
         offsetY         <= '0;
      end else begin
         InsideRectangle <= inside_c;
         offsetX         <= ox_c;
         offsetY         <= oy_c;
      end
   end

   assign livesCount   = lives;
   assign invulnerable = (state == INVULN);
   assign gameOver     = (state == GAME_OVER);

endmodule
